apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

Single-outstanding APB requester that turns a simple valid/ready command stream into compliant APB3 SETUP/ACCESS transfers and returns each result on a valid/ready response channel. It is the initiator end of the APB link and sits between internal logic (a CPU-side or DMA-side command source) and APB completers such as the memory slave `rtl_top`. It replaces hand-driven bus sequencing with synthesizable RTL.

## Interface
Parameters:
- ADDR_WIDTH, 7, APB address width.
- DATA_WIDTH, 32, APB data width.
- TIMEOUT_CYCLES, 16, ACCESS-phase cycle limit, used only with APB_MASTER_TIMEOUT_EN; legal range 1..255.

Ports:
- i_clk  in  1  single clock; all logic on the rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  command accepted when high together with i_cmd_valid.
- i_cmd_write  in  1  1 = write, 0 = read.
- i_cmd_addr  in  ADDR_WIDTH  target address.
- i_cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- o_rsp_valid  out  1  response present; held until accepted.
- i_rsp_ready  in  1  response consumer ready.
- o_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- o_rsp_err  out  1  PSLVERR captured, or timeout.
- o_rsp_timeout  out  1  response ended by watchdog; constant 0 without the macro.
- o_PADDR  out  ADDR_WIDTH  APB address.
- o_PWRITE  out  1  APB direction.
- o_PSEL  out  1  APB select.
- o_PENABLE  out  1  APB enable.
- o_PWDATA  out  DATA_WIDTH  APB write data.
- i_PREADY  in  1  completer ready.
- i_PRDATA  in  DATA_WIDTH  completer read data.
- i_PSLVERR  in  1  completer error.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: o_cmd_ready = !o_rsp_valid || i_rsp_ready. Accept on i_cmd_valid && o_cmd_ready, then latch addr/write/wdata into o_PADDR/o_PWRITE/o_PWDATA and go to SETUP.
- SETUP: o_PSEL=1, o_PENABLE=0. Go to ACCESS unconditionally.
- ACCESS: o_PSEL=1, o_PENABLE=1. Stay while i_PREADY=0. On an edge with i_PREADY=1:
  - Capture i_PRDATA (reads) or 0 (writes) into o_rsp_rdata.
  - Capture i_PSLVERR into o_rsp_err.
  - Set o_rsp_valid and return to IDLE. o_PSEL and o_PENABLE drop in the same edge.
- o_PADDR/o_PWRITE/o_PWDATA are stable from SETUP through the final ACCESS cycle. In IDLE they hold their last values.
- Response register: o_rsp_valid clears on i_rsp_valid && i_rsp_ready unless a new response loads at the same edge; a new load wins.
- One transaction outstanding; o_cmd_ready is 0 in SETUP and ACCESS.
- i_PRDATA/i_PSLVERR are sampled only in ACCESS with i_PREADY=1; at all other times they are ignored.

## Timing
- Reset values: o_PSEL=0, o_PENABLE=0, o_PWRITE=0, o_PADDR=0, o_PWDATA=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_rsp_timeout=0, FSM=IDLE. o_cmd_ready=1 after reset.
- Accept at edge N → SETUP in cycle N..N+1 → ACCESS from edge N+1. With zero wait states, o_rsp_valid=1 after edge N+2. Each wait state adds one cycle.
- Back-to-back: if the response is consumed in the cycle a command is offered, the next SETUP starts one cycle after the previous ACCESS ends. o_PSEL is low for exactly one cycle (IDLE) between transfers.
- Reset asserted mid-transfer: bus outputs drop immediately (asynchronously), the transaction is discarded, and no response is produced.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with i_PREADY=0.
  - When it reaches TIMEOUT_CYCLES, the next edge ends the transfer: o_PSEL/o_PENABLE drop, o_rsp_valid=1, o_rsp_err=1, o_rsp_timeout=1, o_rsp_rdata=0.
  - If i_PREADY=1 on that same edge, the normal completion wins.
- APB_MASTER_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; o_rsp_timeout tied 0.

## Test plan
- Write 0xDEADBEEF to 0x00, zero-wait completer → PSEL high 2 cycles, PENABLE high 1 cycle, PWDATA stable; response err=0, rdata=0.
- Read 0x00 after that write → SETUP/ACCESS sequence; rsp_rdata=0xDEADBEEF two cycles after accept.
- Read 0x7F with 3 wait states (PREADY low 3 ACCESS cycles) → PENABLE high 4 cycles, address stable; response appears on the PREADY edge.
- Completer returns PSLVERR=1 on write to 0x10 → rsp_err=1, rsp_timeout=0. Hold i_rsp_ready=0 for 5 cycles → rsp_valid held and cmd_ready=0 throughout.
- Macro on, TIMEOUT_CYCLES=4, PREADY never asserted → transfer aborted after 4 wait cycles; rsp_err=1, rsp_timeout=1, rdata=0. Next command proceeds normally.
- Assert i_rst_n=0 during ACCESS → PSEL/PENABLE go 0 before the next clock edge; no rsp_valid after release; a subsequent read of 0x10 completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 requester: valid/ready command in, SETUP/ACCESS on APB, valid/ready
// response out. Define APB_MASTER_TIMEOUT_EN to add the ACCESS-phase watchdog.
module apb_master_bridge #(
   parameter int unsigned ADDR_WIDTH     = 7,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic                  i_cmd_write,
   input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
   input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_rsp_rdata,
   output logic                  o_rsp_err,
   output logic                  o_rsp_timeout,
   output logic [ADDR_WIDTH-1:0] o_PADDR,
   output logic                  o_PWRITE,
   output logic                  o_PSEL,
   output logic                  o_PENABLE,
   output logic [DATA_WIDTH-1:0] o_PWDATA,
   input  logic                  i_PREADY,
   input  logic [DATA_WIDTH-1:0] i_PRDATA,
   input  logic                  i_PSLVERR
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic                  pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;

   logic psel, penable, cmd_ready;
   logic accept, complete, timeout_hit;

   assign accept   = (state_q == StIdle) && i_cmd_valid && cmd_ready;
   assign complete = (state_q == StAccess) && i_PREADY;

   // FSM: state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (accept) state_d = StSetup;
         StSetup:  state_d = StAccess;
         StAccess: if (complete || timeout_hit) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // FSM: outputs
   always_comb begin
      psel      = 1'b0;
      penable   = 1'b0;
      cmd_ready = 1'b0;
      case (state_q)
         StIdle:   cmd_ready = !rsp_valid_q || i_rsp_ready;
         StSetup:  psel = 1'b1;
         StAccess: begin
            psel    = 1'b1;
            penable = 1'b1;
         end
         default: ;
      endcase
   end

   // Request registers hold their last values while idle.
   always_comb begin
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
      if (accept) begin
         paddr_d  = i_cmd_addr;
         pwrite_d = i_cmd_write;
         pwdata_d = i_cmd_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
      end else begin
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         pwdata_q <= pwdata_d;
      end
   end

   // A response loading on the same edge as a hand-off wins over the clear.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      if (rsp_valid_q && i_rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
      if (complete) begin
         rsp_valid_d = 1'b1;
         rsp_rdata_d = pwrite_q ? '0 : i_PRDATA;
         rsp_err_d   = i_PSLVERR;
      end else if (timeout_hit) begin
         rsp_valid_d = 1'b1;
         rsp_rdata_d = '0;
         rsp_err_d   = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

`ifdef APB_MASTER_TIMEOUT_EN
   localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

   logic [7:0] tmo_cnt_q, tmo_cnt_d;
   logic       rsp_tmo_q, rsp_tmo_d;

   assign timeout_hit = (state_q == StAccess) && !i_PREADY && (tmo_cnt_q == TimeoutLimit);

   // Cleared during SETUP so it reads zero on the first ACCESS cycle.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_q == StSetup) begin
         tmo_cnt_d = '0;
      end else if ((state_q == StAccess) && !i_PREADY && !timeout_hit) begin
         tmo_cnt_d = tmo_cnt_q + 8'd1;
      end
   end

   always_comb begin
      rsp_tmo_d = rsp_tmo_q;
      if (complete) begin
         rsp_tmo_d = 1'b0;
      end else if (timeout_hit) begin
         rsp_tmo_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tmo_cnt_q <= '0;
         rsp_tmo_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         rsp_tmo_q <= rsp_tmo_d;
      end
   end

   assign o_rsp_timeout = rsp_tmo_q;
`else
   assign timeout_hit   = 1'b0;
   assign o_rsp_timeout = 1'b0;
`endif

   assign o_cmd_ready = cmd_ready;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_rsp_err   = rsp_err_q;
   assign o_PSEL      = psel;
   assign o_PENABLE   = penable;
   assign o_PADDR     = paddr_q;
   assign o_PWRITE    = pwrite_q;
   assign o_PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a small behavioural APB completer (wait states,
// PSLVERR injection, write-back memory over a fixed address pattern).
module tb_apb_master_bridge;

   localparam int unsigned AW = 7;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] paddr;
   logic          pwrite, psel, penable, pready, pslverr;
   logic [DW-1:0] pwdata, prdata;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   apb_master_bridge #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_cmd_valid  (cmd_valid),
      .o_cmd_ready  (cmd_ready),
      .i_cmd_write  (cmd_write),
      .i_cmd_addr   (cmd_addr),
      .i_cmd_wdata  (cmd_wdata),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_rdata  (rsp_rdata),
      .o_rsp_err    (rsp_err),
      .o_rsp_timeout(rsp_timeout),
      .o_PADDR      (paddr),
      .o_PWRITE     (pwrite),
      .o_PSEL       (psel),
      .o_PENABLE    (penable),
      .o_PWDATA     (pwdata),
      .i_PREADY     (pready),
      .i_PRDATA     (prdata),
      .i_PSLVERR    (pslverr)
   );

   // Completer: unwritten locations read as 0xA5000000 | addr.
   logic [DW-1:0] mem [128];
   logic [127:0]  wr_mask = '0;
   int            wait_states = 0;
   int            wait_cnt = 0;
   logic          slv_err = 1'b0;

   assign pready  = psel && penable && (wait_cnt == wait_states);
   assign pslverr = slv_err && pready;
   assign prdata  = wr_mask[paddr] ? mem[paddr] : (32'hA500_0000 | 32'(paddr));

   always @(posedge clk) begin
      if (psel && penable && !pready) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
      if (psel && penable && pready && pwrite && !slv_err) begin
         mem[paddr]     <= pwdata;
         wr_mask[paddr] <= 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   // Issues one command and measures the transfer until the response appears.
   task automatic run_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int psel_cyc, output int pen_cyc, output int lat,
                           output bit stable, output bit ok);
      ok = 1'b0; psel_cyc = 0; pen_cyc = 0; lat = 0; stable = 1'b1;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      #1;
      for (int i = 0; i < 20 && !cmd_ready; i++) tick();
      if (cmd_ready) begin
         tick();
         cmd_valid = 1'b0;
         for (int i = 0; i < 300 && !ok; i++) begin
            if (rsp_valid) begin
               ok = 1'b1;
            end else begin
               if (psel) psel_cyc++;
               if (penable) pen_cyc++;
               if (psel && (paddr !== a || pwrite !== wr || pwdata !== d)) stable = 1'b0;
               tick();
               lat++;
            end
         end
      end
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0;
      repeat (3) tick();
      checks++; if ({psel, penable, pwrite} !== 3'b000) begin errors++;
         $display("FAIL reset_ctrl: psel/penable/pwrite=%b want 000", {psel, penable, pwrite}); end
      checks++; if (paddr !== '0 || pwdata !== '0) begin errors++;
         $display("FAIL reset_bus: paddr=%h pwdata=%h want 0", paddr, pwdata); end
      checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b000 || rsp_rdata !== '0) begin
         errors++; $display("FAIL reset_rsp: v/e/t=%b rdata=%h want 000/0",
                            {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata); end
      rst_n = 1'b1;
      tick();
      checks++; if (cmd_ready !== 1'b1) begin errors++;
         $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
   endtask

   task automatic test_write();
      int pc, ec, lat; bit st, ok;
      run_xfer(1'b1, 7'h00, 32'hDEADBEEF, pc, ec, lat, st, ok);
      checks++; if (!ok || lat != 2) begin errors++;
         $display("FAIL wr_latency: ok=%0d lat=%0d want 1/2", ok, lat); end
      checks++; if (pc != 2 || ec != 1) begin errors++;
         $display("FAIL wr_phases: psel=%0d penable=%0d want 2/1", pc, ec); end
      checks++; if (!st) begin errors++; $display("FAIL wr_stable: got 0 want 1"); end
      checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
         errors++; $display("FAIL wr_rsp: rdata=%h err=%b tmo=%b want 0/0/0",
                            rsp_rdata, rsp_err, rsp_timeout); end
      consume();
      checks++; if (rsp_valid !== 1'b0) begin errors++;
         $display("FAIL wr_consume: rsp_valid=%b want 0", rsp_valid); end
   endtask

   task automatic test_read_after_write();
      int pc, ec, lat; bit st, ok;
      run_xfer(1'b0, 7'h00, 32'h0, pc, ec, lat, st, ok);
      checks++; if (!ok || lat != 2 || pc != 2 || ec != 1) begin errors++;
         $display("FAIL rd_timing: ok=%0d lat=%0d psel=%0d pen=%0d want 1/2/2/1",
                  ok, lat, pc, ec); end
      checks++; if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin errors++;
         $display("FAIL rd_data: rdata=%h err=%b want deadbeef/0", rsp_rdata, rsp_err); end
      consume();
   endtask

   task automatic test_wait_states();
      int pc, ec, lat; bit st, ok;
      wait_states = 3;
      run_xfer(1'b0, 7'h7F, 32'h0, pc, ec, lat, st, ok);
      wait_states = 0;
      checks++; if (!ok || lat != 5 || pc != 5 || ec != 4) begin errors++;
         $display("FAIL ws_timing: ok=%0d lat=%0d psel=%0d pen=%0d want 1/5/5/4",
                  ok, lat, pc, ec); end
      checks++; if (!st) begin errors++; $display("FAIL ws_stable: got 0 want 1"); end
      checks++; if (rsp_rdata !== 32'hA500007F) begin errors++;
         $display("FAIL ws_data: rdata=%h want a500007f", rsp_rdata); end
      consume();
   endtask

   task automatic test_slverr_hold();
      int pc, ec, lat; bit st, ok;
      slv_err = 1'b1;
      run_xfer(1'b1, 7'h10, 32'h12345678, pc, ec, lat, st, ok);
      slv_err = 1'b0;
      checks++; if (!ok || rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== '0) begin
         errors++; $display("FAIL err_rsp: ok=%0d err=%b tmo=%b rdata=%h want 1/1/0/0",
                            ok, rsp_err, rsp_timeout, rsp_rdata); end
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h11;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || psel !== 1'b0) begin
            errors++; $display("FAIL hold_%0d: rsp_valid=%b cmd_ready=%b psel=%b want 1/0/0",
                               i, rsp_valid, cmd_ready, psel); end
         tick();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++;
         $display("FAIL hold_release: cmd_ready=%b want 1", cmd_ready); end
      tick();
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0 || psel !== 1'b0) begin errors++;
         $display("FAIL hold_drained: rsp_valid=%b psel=%b want 0/0", rsp_valid, psel); end
   endtask

   task automatic test_back_to_back();
      int pc, ec, lat; bit st, ok;
      run_xfer(1'b0, 7'h01, 32'h0, pc, ec, lat, st, ok);
      checks++; if (!ok || rsp_rdata !== 32'hA5000001) begin errors++;
         $display("FAIL b2b_first: ok=%0d rdata=%h want 1/a5000001", ok, rsp_rdata); end
      rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h02; cmd_wdata = '0;
      #1;
      checks++; if (psel !== 1'b0 || cmd_ready !== 1'b1) begin errors++;
         $display("FAIL b2b_gap: psel=%b cmd_ready=%b want 0/1", psel, cmd_ready); end
      tick();
      rsp_ready = 1'b0; cmd_valid = 1'b0;
      checks++; if ({psel, penable} !== 2'b10 || paddr !== 7'h02 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_setup: psel/pen=%b paddr=%h rsp_valid=%b want 10/02/0",
                            {psel, penable}, paddr, rsp_valid); end
      tick();
      checks++; if ({psel, penable} !== 2'b11) begin errors++;
         $display("FAIL b2b_access: psel/pen=%b want 11", {psel, penable}); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5000002 || psel !== 1'b0) begin
         errors++; $display("FAIL b2b_rsp: valid=%b rdata=%h psel=%b want 1/a5000002/0",
                            rsp_valid, rsp_rdata, psel); end
      consume();
   endtask

   task automatic test_reset_mid();
      int pc, ec, lat; bit st, ok;
      wait_states = 10;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h20; cmd_wdata = '0;
      tick();
      cmd_valid = 1'b0;
      tick();
      checks++; if (penable !== 1'b1) begin errors++;
         $display("FAIL rstmid_pre: penable=%b want 1", penable); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (psel !== 1'b0 || penable !== 1'b0) begin errors++;
         $display("FAIL rstmid_async: psel=%b penable=%b want 0/0", psel, penable); end
      tick(); tick();
      rst_n = 1'b1;
      wait_states = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (rsp_valid !== 1'b0 || psel !== 1'b0) begin errors++;
            $display("FAIL rstmid_quiet_%0d: rsp_valid=%b psel=%b want 0/0", i, rsp_valid, psel);
         end
      end
      run_xfer(1'b0, 7'h10, 32'h0, pc, ec, lat, st, ok);
      checks++; if (!ok || lat != 2 || rsp_rdata !== 32'hA5000010 || rsp_err !== 1'b0) begin
         errors++; $display("FAIL rstmid_after: ok=%0d lat=%0d rdata=%h err=%b want 1/2/a5000010/0",
                            ok, lat, rsp_rdata, rsp_err); end
      consume();
   endtask

`ifdef APB_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      int pc, ec, lat; bit st, ok;
      wait_states = 1000;
      run_xfer(1'b0, 7'h05, 32'h0, pc, ec, lat, st, ok);
      wait_states = 0;
      checks++; if (!ok || ec != 5 || lat != 6) begin errors++;
         $display("FAIL tmo_timing: ok=%0d pen=%0d lat=%0d want 1/5/6", ok, ec, lat); end
      checks++; if (rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== '0) begin
         errors++; $display("FAIL tmo_rsp: err=%b tmo=%b rdata=%h want 1/1/0",
                            rsp_err, rsp_timeout, rsp_rdata); end
      consume();
      run_xfer(1'b0, 7'h06, 32'h0, pc, ec, lat, st, ok);
      checks++; if (!ok || rsp_rdata !== 32'hA5000006 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0)
      begin errors++; $display("FAIL tmo_next: ok=%0d rdata=%h err=%b tmo=%b want 1/a5000006/0/0",
                               ok, rsp_rdata, rsp_err, rsp_timeout); end
      consume();
   endtask
`else
   task automatic test_long_wait();
      int pc, ec, lat; bit st, ok;
      wait_states = 30;
      run_xfer(1'b0, 7'h05, 32'h0, pc, ec, lat, st, ok);
      wait_states = 0;
      checks++; if (!ok || ec != 31 || lat != 32) begin errors++;
         $display("FAIL long_timing: ok=%0d pen=%0d lat=%0d want 1/31/32", ok, ec, lat); end
      checks++; if (rsp_rdata !== 32'hA5000005 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
         errors++; $display("FAIL long_rsp: rdata=%h err=%b tmo=%b want a5000005/0/0",
                            rsp_rdata, rsp_err, rsp_timeout); end
      consume();
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_read_after_write();
      test_wait_states();
      test_slverr_hold();
      test_back_to_back();
      test_reset_mid();
`ifdef APB_MASTER_TIMEOUT_EN
      test_timeout();
`else
      test_long_wait();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
